// File: rtl/uart_regs_pkg.sv
// Shared register map, bit positions and reset constants for the UART APB
// register block and its helpers.
package uart_regs_pkg;

  localparam int unsigned ADDR_DATA   = 32'h00;
  localparam int unsigned ADDR_STATUS = 32'h04;
  localparam int unsigned ADDR_DIV    = 32'h08;
  localparam int unsigned ADDR_IRQ_EN = 32'h0C;

  localparam int STAT_RXNE      = 0;
  localparam int STAT_TXFULL    = 1;
  localparam int STAT_TXEMPTY   = 2;
  localparam int STAT_LEVEL_LSB = 4;
  localparam int STAT_LEVEL_W   = 3;
  localparam int STAT_TXOVF     = 8;

  localparam int IRQ_RXNE    = 0;
  localparam int IRQ_TXEMPTY = 1;
  localparam int IRQ_TXOVF   = 2;

  localparam int unsigned DIV_INT_RST_DEFAULT  = 108;
  localparam int unsigned DIV_FRAC_RST_DEFAULT = 8;

  typedef enum logic [2:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_DIV,
    SEL_IRQ_EN,
    SEL_NONE
  } reg_sel_e;

  // Misaligned or out-of-range byte addresses fall through to SEL_NONE.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_DATA:   sel = SEL_DATA;
      ADDR_STATUS: sel = SEL_STATUS;
      ADDR_DIV:    sel = SEL_DIV;
      ADDR_IRQ_EN: sel = SEL_IRQ_EN;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_credit.sv
// Tracks how many bytes sit in the core TX FIFO: counts accepted pushes up and
// completed frames (rising edge of tx_done) down, saturating at 0 and DEPTH.
module uart_tx_credit #(
  parameter int DEPTH = 5,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             tx_done,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic done_q;
  logic inc;
  logic dec;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A frame completion seen while already empty is spurious and dropped.
  assign inc = push & ~full;
  assign dec = tx_done & ~done_q & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      level  <= '0;
    end else begin
      done_q <= tx_done;
      case ({inc, dec})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_regs.sv
// APB3 register front end for uart_core: divisor, TX push with credit
// tracking, RX pop, sticky TX overflow and a maskable interrupt.
module uart_apb_regs
  import uart_regs_pkg::*;
#(
  parameter int          ADDR_W       = 5,
  parameter int          TX_DEPTH     = 5,
  parameter int unsigned DIV_INT_RST  = DIV_INT_RST_DEFAULT,
  parameter int unsigned DIV_FRAC_RST = DIV_FRAC_RST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [9:0]        div_int,
  output logic [3:0]        div_frac,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_done,
  input  logic [7:0]        rx_byte,
  input  logic              rx_irq,
  output logic              rxfifo_ren_ext,
  output logic              irq
);

  localparam int LVL_W = $clog2(TX_DEPTH + 1);

  reg_sel_e         sel;
  logic             acc;
  logic             wr;
  logic             rd;
  logic             data_wr;
  logic             push;
  logic             ovf_set;
  logic             txovf;
  logic [2:0]       irq_en;
  logic [LVL_W-1:0] tx_level;
  logic             tx_full;
  logic             tx_empty;
  logic [31:0]      status;
  logic             unused_pwdata;

  assign sel     = decode_addr(32'(paddr));
  assign acc     = psel & penable;
  assign wr      = acc & pwrite;
  assign rd      = acc & ~pwrite;
  assign data_wr = wr & (sel == SEL_DATA);
  assign push    = data_wr & ~tx_full;
  assign ovf_set = data_wr & tx_full;

  assign pready         = 1'b1;
  assign pslverr        = acc & (sel == SEL_NONE);
  assign rxfifo_ren_ext = rd & (sel == SEL_DATA) & rx_irq;
  assign unused_pwdata  = ^{pwdata[31:20], pwdata[15:10]};

  uart_tx_credit #(
    .DEPTH (TX_DEPTH),
    .LVL_W (LVL_W)
  ) u_tx_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .tx_done (tx_done),
    .level   (tx_level),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  always_comb begin
    status                                       = '0;
    status[STAT_RXNE]                            = rx_irq;
    status[STAT_TXFULL]                          = tx_full;
    status[STAT_TXEMPTY]                         = tx_empty;
    status[STAT_LEVEL_LSB +: STAT_LEVEL_W]       = STAT_LEVEL_W'(tx_level);
    status[STAT_TXOVF]                           = txovf;
  end

  // Read data only drives during a read access phase; unmapped reads return 0.
  always_comb begin
    prdata = '0;
    if (rd) begin
      case (sel)
        SEL_DATA:   prdata[7:0] = rx_irq ? rx_byte : 8'h00;
        SEL_STATUS: prdata = status;
        SEL_DIV: begin
          prdata[9:0]   = div_int;
          prdata[19:16] = div_frac;
        end
        SEL_IRQ_EN: prdata[2:0] = irq_en;
        default:    prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= push;
      if (push) tx_byte <= pwdata[7:0];
    end
  end

  // A zero integer divisor would stall the baud generator, so it loads as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int  <= 10'(DIV_INT_RST);
      div_frac <= 4'(DIV_FRAC_RST);
      irq_en   <= '0;
    end else if (wr) begin
      if (sel == SEL_DIV) begin
        div_int  <= (pwdata[9:0] == 10'd0) ? 10'd1 : pwdata[9:0];
        div_frac <= pwdata[19:16];
      end
      if (sel == SEL_IRQ_EN) irq_en <= pwdata[2:0];
    end
  end

  // Overflow set takes priority over a same-cycle write-1 clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txovf <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (ovf_set)
        txovf <= 1'b1;
      else if (wr && sel == SEL_STATUS && pwdata[STAT_TXOVF])
        txovf <= 1'b0;
      irq <= (irq_en[IRQ_RXNE] & rx_irq) |
             (irq_en[IRQ_TXEMPTY] & tx_empty) |
             (irq_en[IRQ_TXOVF] & txovf);
    end
  end

endmodule

// File: tb/tb_uart_apb_regs.sv
// Self-checking bench for uart_apb_regs: directed register scenarios plus
// randomized APB traffic, compared every cycle against a behavioural model.
module tb_uart_apb_regs;

  localparam int TX_DEPTH = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [9:0]  div_int;
  logic [3:0]  div_frac;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_irq = 1'b0;
  logic        rxfifo_ren_ext;
  logic        irq;

  always #5 clk = ~clk;

  uart_apb_regs #(
    .ADDR_W       (5),
    .TX_DEPTH     (TX_DEPTH),
    .DIV_INT_RST  (108),
    .DIV_FRAC_RST (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .div_int        (div_int),
    .div_frac       (div_frac),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .tx_done        (tx_done),
    .rx_byte        (rx_byte),
    .rx_irq         (rx_irq),
    .rxfifo_ren_ext (rxfifo_ren_ext),
    .irq            (irq)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the register block, advanced on each clock edge.
  int         m_level;
  bit         m_ovf, m_irq, m_tx_valid, m_done_q;
  logic [9:0] m_div_int;
  logic [3:0] m_div_frac;
  logic [2:0] m_irq_en;
  logic [7:0] m_tx_byte;
  bit         mw, mpush, movf, mdec, mirq;
  int         midx;

  function automatic bit is_mapped(input logic [4:0] a);
    return (a % 4 == 0) && (a < 16);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!is_mapped(a)) return 32'h0;
    case (int'(a) / 4)
      0:       return rx_irq ? {24'h0, rx_byte} : 32'h0;
      1:       return (m_ovf ? 32'h100 : 32'h0) | 32'(m_level * 16) |
                      (m_level == 0 ? 32'h4 : 32'h0) |
                      (m_level == TX_DEPTH ? 32'h2 : 32'h0) |
                      (rx_irq ? 32'h1 : 32'h0);
      2:       return {12'h0, m_div_frac, 6'h0, m_div_int};
      default: return {29'h0, m_irq_en};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = 0; m_ovf = 0; m_irq = 0; m_tx_valid = 0; m_done_q = 0;
      m_div_int = 10'd108; m_div_frac = 4'd8; m_irq_en = 3'd0; m_tx_byte = 8'h00;
    end else begin
      mw    = psel && penable && pwrite && is_mapped(paddr);
      midx  = int'(paddr) / 4;
      mpush = mw && midx == 0 && m_level < TX_DEPTH;
      movf  = mw && midx == 0 && m_level == TX_DEPTH;
      mdec  = tx_done && !m_done_q && m_level > 0;
      mirq  = (m_irq_en[0] && rx_irq) || (m_irq_en[1] && m_level == 0) || (m_irq_en[2] && m_ovf);
      m_level = m_level + int'(mpush) - int'(mdec);
      if (movf) m_ovf = 1;
      else if (mw && midx == 1 && pwdata[8]) m_ovf = 0;
      if (mw && midx == 2) begin
        m_div_int  = (pwdata[9:0] == 0) ? 10'd1 : pwdata[9:0];
        m_div_frac = pwdata[19:16];
      end
      if (mw && midx == 3) m_irq_en = pwdata[2:0];
      m_tx_valid = mpush;
      if (mpush) m_tx_byte = pwdata[7:0];
      m_done_q = tx_done;
      m_irq = mirq;
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  bit cacc;
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      cacc = psel && penable;
      check_output("tx_valid", tx_valid, m_tx_valid);
      if (m_tx_valid) check_output("tx_byte", tx_byte, m_tx_byte);
      check_output("div_int", div_int, m_div_int);
      check_output("div_frac", div_frac, m_div_frac);
      check_output("irq", irq, m_irq);
      check_output("pready", pready, 1);
      check_output("rxfifo_ren", rxfifo_ren_ext, cacc && !pwrite && paddr == 0 && rx_irq);
      if (cacc) begin
        check_output("pslverr", pslverr, !is_mapped(paddr));
        if (!pwrite) check_output("prdata", prdata, exp_read(paddr));
      end
    end
  end

  int valid_cnt = 0;
  int ren_cnt = 0;
  always @(negedge clk) begin
    if (tx_valid) valid_cnt++;
    if (rxfifo_ren_ext) ren_cnt++;
  end

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    psel = 1; pwrite = 1; penable = 0; paddr = a; pwdata = d;
    @(posedge clk); #2;
    penable = 1;
    @(posedge clk); #2;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #2;
    psel = 1; pwrite = 0; penable = 0; paddr = a;
    @(posedge clk); #2;
    penable = 1;
    @(negedge clk);
    d = prdata; e = pslverr;
    @(posedge clk); #2;
    psel = 0; penable = 0;
  endtask

  task automatic pulse_done(input int hi);
    @(posedge clk); #2;
    tx_done = 1;
    repeat (hi) @(posedge clk);
    #2 tx_done = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic read_expect(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check_output(name, d, exp);
  endtask

  logic [31:0] rd;
  logic        er;
  int          v0, r0;
  logic [31:0] wd;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    cmp_en = 1;
    @(negedge clk);
    check_output("rst_tx_valid", tx_valid, 0);
    check_output("rst_tx_byte", tx_byte, 0);
    check_output("rst_irq", irq, 0);
    check_output("rst_div_int", div_int, 108);
    check_output("rst_div_frac", div_frac, 8);
    check_output("rst_prdata", prdata, 0);
    check_output("rst_pslverr", pslverr, 0);
    check_output("rst_ren", rxfifo_ren_ext, 0);

    read_expect("rst_div", 5'h08, 32'h0008006C);
    read_expect("rst_status", 5'h04, 32'h00000004);
    read_expect("rst_irq_en", 5'h0C, 32'h0);

    apb_write(5'h08, 32'h00030000);
    read_expect("div_zero_int", 5'h08, 32'h00030001);
    check_output("div_int_one", div_int, 1);
    apb_read(5'h14, rd, er);
    check_output("unmapped_prdata", rd, 0);
    check_output("unmapped_pslverr", er, 1);
    apb_read(5'h02, rd, er);
    check_output("misaligned_pslverr", er, 1);

    v0 = valid_cnt;
    for (int i = 0; i < 6; i++) apb_write(5'h00, 32'h41 + 32'(i));
    repeat (2) @(posedge clk);
    check_output("push_count", valid_cnt - v0, 5);
    check_output("last_tx_byte", tx_byte, 8'h45);
    rx_irq = 1;
    read_expect("status_full_rxne", 5'h04, 32'h153);
    rx_irq = 0;
    read_expect("status_full", 5'h04, 32'h152);
    apb_write(5'h04, 32'h100);
    read_expect("status_w1c", 5'h04, 32'h052);

    for (int i = 1; i <= 5; i++) begin
      pulse_done(16);
      read_expect("status_drain", 5'h04,
                  32'((5 - i) * 16) | ((i == 5) ? 32'h4 : 32'h0));
    end
    pulse_done(16);
    read_expect("status_sat_zero", 5'h04, 32'h4);

    apb_write(5'h00, 32'h11);
    apb_write(5'h00, 32'h22);
    @(posedge clk); #2;
    psel = 1; pwrite = 1; penable = 0; paddr = 5'h00; pwdata = 32'h33;
    @(posedge clk); #2;
    penable = 1; tx_done = 1;
    @(posedge clk); #2;
    psel = 0; penable = 0; pwrite = 0;
    repeat (3) @(posedge clk);
    #2 tx_done = 0;
    read_expect("status_coincident", 5'h04, 32'h20);
    pulse_done(3);
    pulse_done(3);
    read_expect("status_empty_again", 5'h04, 32'h4);

    rx_irq = 1; rx_byte = 8'h5A;
    r0 = ren_cnt;
    read_expect("rx_data", 5'h00, 32'h5A);
    @(posedge clk);
    check_output("rx_pop_count", ren_cnt - r0, 1);
    rx_irq = 0;
    read_expect("rx_empty_data", 5'h00, 32'h0);
    @(posedge clk);
    check_output("rx_no_pop", ren_cnt - r0, 1);

    apb_write(5'h0C, 32'h2);
    @(negedge clk);
    check_output("irq_lag", irq, 0);
    @(negedge clk);
    check_output("irq_txempty", irq, 1);
    apb_write(5'h00, 32'h77);
    @(negedge clk);
    check_output("irq_hold", irq, 1);
    @(negedge clk);
    check_output("irq_drop", irq, 0);
    pulse_done(3);

    for (int n = 0; n < 300; n++) begin
      rx_irq  = 1'($urandom_range(0, 1));
      rx_byte = 8'($urandom);
      if (m_level > 0 && $urandom_range(0, 3) == 0) pulse_done(int'($urandom_range(1, 4)));
      wd = $urandom;
      case ($urandom_range(0, 6))
        0, 1, 2: apb_write(5'h00, wd);
        3: apb_write(5'h04, wd);
        4: begin
          if ($urandom_range(0, 3) == 0) wd[9:0] = 10'd0;
          apb_write(5'h08, wd);
        end
        5: apb_write(5'h0C, wd);
        default: apb_read(5'($urandom_range(0, 31)), rd, er);
      endcase
    end

    apb_write(5'h08, 32'h000500AA);
    apb_write(5'h0C, 32'h7);
    apb_write(5'h00, 32'h99);
    @(posedge clk); #3;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    rx_irq = 0;
    @(negedge clk);
    check_output("midreset_irq", irq, 0);
    check_output("midreset_tx_valid", tx_valid, 0);
    read_expect("midreset_div", 5'h08, 32'h0008006C);
    read_expect("midreset_status", 5'h04, 32'h4);
    read_expect("midreset_irq_en", 5'h0C, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_regs.md
# uart_apb_regs

APB3 slave register block sitting directly upstream of `uart_core`: it turns CPU bus accesses into the core's control inputs (`div_int`, `div_frac`, `tx_byte`/`tx_valid`, `rxfifo_ren_ext`) and consumes its outputs (`rx_byte`, `rx_irq`, `tx_done`). It tracks TX occupancy itself, because the core exposes no TX-full flag. It also provides sticky overflow status and a maskable interrupt.

## Interface
- `ADDR_W`, 5: APB address width, byte address; word offsets 0x00–0x0C are mapped.
- `TX_DEPTH`, 5: TX credit limit, equal to the core TX FIFO depth.
- `DIV_INT_RST`, 108: reset value of `div_int`.
- `DIV_FRAC_RST`, 8: reset value of `div_frac`.
- `clk` in 1: single clock, shared with `uart_core`.
- `rst_n` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1 each: APB3 control.
- `paddr` in ADDR_W: APB3 address.
- `pwdata` in 32: APB3 write data.
- `prdata` out 32: read data; combinational, valid during the access phase.
- `pready` out 1: tied 1 (no wait states).
- `pslverr` out 1: high during an access phase to an unmapped offset.
- `div_int` out 10, `div_frac` out 4: baud divisor to the core.
- `tx_byte` out 8, `tx_valid` out 1: TX push to the core; registered, single-cycle pulse.
- `tx_done` in 1: core level, high for one bit-time at the end of each frame.
- `rx_byte` in 8: head of the core RX FIFO.
- `rx_irq` in 1: core RX FIFO not empty.
- `rxfifo_ren_ext` out 1: RX pop; combinational.
- `irq` out 1: registered interrupt.

## Operation
- Access strobe: `acc = psel & penable`. Writes and reads take effect on the clock edge that ends the access phase.
- DATA register, offset 0x00:
  - Write with `tx_level < TX_DEPTH`: `tx_byte <= pwdata[7:0]`, `tx_valid <= 1` for one cycle, `tx_level` +1.
  - Write with `tx_level == TX_DEPTH`: no push; set sticky `TXOVF`.
  - Read: `prdata[7:0] = rx_byte` when `rx_irq`, else 0. `rxfifo_ren_ext = acc & !pwrite & DATA & rx_irq`.
- STATUS register, offset 0x04:
  - bit0 `RXNE` = `rx_irq`.
  - bit1 `TXFULL` = (`tx_level == TX_DEPTH`).
  - bit2 `TXEMPTY` = (`tx_level == 0`).
  - bits[6:4] `tx_level`.
  - bit8 `TXOVF`: sticky; writing 1 clears it.
  - All other bits read 0.
- DIV register, offset 0x08: bits[9:0] `div_int`, bits[19:16] `div_frac`, read/write.
  - A write with `div_int == 0` stores 1; the divisor must never load 0.
- IRQ_EN register, offset 0x0C: bit0 RXNE, bit1 TXEMPTY, bit2 TXOVF.
  - `irq <= |(IRQ_EN[2:0] & {TXOVF, TXEMPTY, RXNE})`.
- Unmapped offset (0x10 and above, or `paddr[1:0] != 0`): `pslverr=1`, `prdata=0`, no state change.
- TX credit: `tx_done_q` registers `tx_done`.
  - Decrement `tx_level` on the rising edge `tx_done & !tx_done_q`, exactly once per frame.
  - Simultaneous accepted push and `tx_done` rise: `tx_level` unchanged, no overflow.
  - A `tx_done` rise at `tx_level == 0` is ignored; the counter saturates and never wraps.
- TXOVF: a write-1 clear in the same cycle as a new overflow leaves TXOVF set; set wins.

## Timing
- Reset values:
  - `prdata` 0, `pslverr` 0, `pready` 1.
  - `div_int = DIV_INT_RST`, `div_frac = DIV_FRAC_RST`.
  - `tx_byte` 0, `tx_valid` 0, `rxfifo_ren_ext` 0, `irq` 0.
  - `tx_level` 0, `TXOVF` 0, `IRQ_EN` 0, `tx_done_q` 0.
- Write to DATA: `tx_valid` is high in the cycle after the access edge (latency 1).
- Write to DIV: new value is visible on `div_int`/`div_frac` in the cycle after the access edge.
- Read of DATA: pop occurs at the access edge. Back-to-back APB reads (2 cycles minimum each) see successive bytes.
- `irq` lags any status change by 1 cycle.
- Reset mid-frame returns every register to its reset value; the core is reset by the same `rst_n`, so `tx_level` 0 stays coherent.

## Structure
- `uart_regs_pkg` holds:
  - offsets `ADDR_DATA`, `ADDR_STATUS`, `ADDR_DIV`, `ADDR_IRQ_EN`;
  - STATUS and IRQ_EN bit indices;
  - the divisor reset constants.
- Sub-module `uart_tx_credit`: `tx_done` edge detect, saturating 0..TX_DEPTH counter, full/empty flags.
- Top level holds the APB decode and register file, and instantiates `uart_tx_credit` once.

## Test plan
- Reset, then read every register: DIV returns 0x0008006C, STATUS returns 0x00000004, IRQ_EN returns 0, `irq` is 0.
- Write DIV with 0x00030000: reads back 0x00030001 and `div_int` is 1. Read offset 0x14: `pslverr`=1, `prdata`=0.
- Six DATA writes 0x41..0x46 with no `tx_done`:
  - five `tx_valid` pulses;
  - STATUS reads 0x153 when `rx_irq`=1, else 0x152;
  - the sixth write sets TXOVF;
  - W1C of bit8 clears it.
- Pulse `tx_done` for 16 cycles, five times, with `tx_level`=5: level steps down 5→0, one decrement per pulse. Push coincident with a `tx_done` rise: level unchanged.
- Drive `rx_irq`=1 and `rx_byte`=0x5A, read DATA: `prdata`=0x5A and `rxfifo_ren_ext` is high for exactly the access cycle. With `rx_irq`=0: `prdata`=0, no pop.
- Set IRQ_EN=0x2 with `tx_level` 0: `irq`=1 one cycle later. Push one byte: `irq` deasserts one cycle after `tx_level` becomes 1.
